simon_iter_core: RTL
====================

Name: simon_iter_core

Overview:
- Parametrised, iterative SIMON block cipher engine that performs both encryption and decryption, selected per block.
- Supports the SIMON 2n/mn family: word width, key words and round count are parameters.
- Executes one round per clock over a shared round datapath. Round keys are expanded once per key load into an internal key store, so decryption can walk them in reverse.
- Sits between the host load/unload logic and the crypto bus as a drop-in, low-area replacement for fully unrolled encrypt/decrypt instances.

Parameters:
- WORD_W, 32, cipher word width n in bits; block is 2*WORD_W. Legal values: 16, 24, 32, 48, 64.
- KEY_WORDS, 4, key length m in words. Legal values: 2, 3, 4.
- ROUNDS, 44, number of rounds T. Must be >= KEY_WORDS.
- Z_IDX, 3, index (0..4) of the z constant sequence used by the key schedule.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  key_in is presented.
- key_ready  out  1  core can accept a new key.
- key_in  in  KEY_WORDS*WORD_W  master key. MSB word is k[m-1]; LSB word is k[0].
- in_valid  in  1  block presented.
- in_ready  out  1  core can accept a block.
- in_decrypt  in  1  1 = decrypt, 0 = encrypt; sampled on accept.
- in_data  in  2*WORD_W  block {x, y}; x occupies the upper WORD_W bits.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_data  out  2*WORD_W  result {x, y}.
- key_loaded  out  1  the key store holds a complete schedule.

Behaviour:
- Reset: all outputs 0 except key_ready = 1. key_loaded = 0, state IDLE, round counter 0. Key store contents are don't-care.
- Round function: f(x) = (ROL1 x & ROL8 x) ^ ROL2 x. Encrypt round: (x, y) <- (y ^ f(x) ^ k_i, x).
- Decrypt: swap the block halves, run rounds with keys k[T-1] down to k[0], then swap the halves back. The same round datapath serves both directions.
- Key schedule, with t = ROR3 k[i+m-1]:
  - if m = 4, t ^= k[i+1];
  - then t ^= ROR1 t;
  - k[i+m] = ~k[i] ^ t ^ z[Z_IDX][(i) mod 62] ^ 3.
- States: IDLE, KEXP, RUN, DONE.
- IDLE:
  - key_ready = 1; in_ready = key_loaded.
  - key_valid & key_ready -> KEXP. key_loaded drops to 0 on the same edge.
  - Otherwise, in_valid & in_ready -> RUN: latch the block (halves swapped if decrypting), latch mode, clear the counter.
  - If key_valid and in_valid are both asserted in the same cycle, the key wins and in_ready is 0 in that cycle.
- KEXP:
  - Writes exactly one key word per cycle, k[0] .. k[T-1], for T cycles. The first m writes are the master key words.
  - key_ready = 0, in_ready = 0.
  - After the write of k[T-1]: key_loaded = 1, go to IDLE. New key_valid pulses are ignored while in KEXP.
- RUN:
  - One round per edge, using k[cnt] (encrypt) or k[T-1-cnt] (decrypt).
  - After the round with cnt = T-1, go to DONE. The result (halves swapped back if decrypting) is registered into out_data and out_valid is set on that same edge.
  - Latency: block accepted at edge E -> out_valid high after edge E+T.
- DONE:
  - out_valid = 1 with out_data stable until out_valid & out_ready.
  - On that handshake: out_valid = 0 on the next edge, go to IDLE.
  - in_ready = 0 and key_ready = 0 throughout DONE. There is no overlap of blocks.
- Back-pressure: a consumer holding out_ready = 0 stalls the core indefinitely without data loss.
- Reset mid-operation (KEXP, RUN or DONE): return to the reset state on the next edge. Any in-flight block is discarded, and key_loaded = 0, so a new key is required.
- Round counter width: clog2(ROUNDS). All rotations are mod WORD_W. NOT and XOR are bitwise over WORD_W bits.

Decomposition:
- simon_pkg holds:
  - the five 62-bit z sequence constants;
  - the state enum;
  - rol/ror functions parametrised by width;
  - a function deriving the counter width from ROUNDS.
- One sub-module, simon_key_store: a ROUNDS x WORD_W register file with one write port and one read port, plus the key-expansion datapath and write counter. It exposes wr_start, busy, done, rd_addr and rd_key.
- The round datapath and FSM stay in simon_iter_core.

Test Plan:
- Defaults, key 1b1a1918_13121110_0b0a0908_03020100, encrypt 656b696c_20646e75 -> out_data 44c8fc20_b9dfa07a. out_valid rises exactly 44 edges after accept, and the key load takes exactly 44 cycles.
- Same key, decrypt 44c8fc20_b9dfa07a -> 656b696c_20646e75. Then back-to-back encrypt and decrypt blocks with no new key load -> both results correct.
- Hold out_ready = 0 for 20 cycles after out_valid -> out_data stable, in_ready = 0, key_ready = 0. Release -> out_valid falls the next cycle and in_ready returns to 1.
- Assert key_valid and in_valid together in IDLE -> key accepted and block not accepted (in_ready = 0). The block is accepted only after key_loaded = 1. Also in_valid before any key after reset -> never accepted.
- Assert rst mid-RUN at round 20 -> next cycle out_valid = 0, key_loaded = 0, key_ready = 1. Reload the key and rerun the first vector -> correct ciphertext.
- WORD_W = 16, KEY_WORDS = 4, ROUNDS = 32, Z_IDX = 0, key 1918_1110_0908_0100, encrypt 6565_6877 -> c69b_e9bb. Decrypt it back -> 6565_6877.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared SIMON definitions: z sequences, FSM states, width-generic rotates.
package simon_pkg;

  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEXP = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int cnt_w(input int rounds);
    return (rounds > 1) ? $clog2(rounds) : 1;
  endfunction

  // Rotate within the low w bits of a 64-bit container; upper bits return 0.
  function automatic logic [63:0] rol(input logic [63:0] x, input int w, input int s);
    logic [63:0] m;
    logic [63:0] v;
    m = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    v = x & m;
    return ((v << s) | (v >> (w - s))) & m;
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int w, input int s);
    return rol(x, w, w - s);
  endfunction

  // Sequence bit i of z[idx]; bit 0 is the leftmost digit of the published string.
  function automatic logic z_bit(input int idx, input logic [5:0] i);
    logic [61:0] z;
    case (idx)
      0:       z = Z0;
      1:       z = Z1;
      2:       z = Z2;
      3:       z = Z3;
      default: z = Z4;
    endcase
    return z[6'd61 - i];
  endfunction

endpackage

// File: rtl/simon_iter_core_if.sv
// Host-side key/block/result handshakes of the iterative SIMON core.
interface simon_iter_core_if #(
  parameter int WORD_W    = 32,
  parameter int KEY_WORDS = 4
);
  logic                          key_valid;
  logic                          key_ready;
  logic [KEY_WORDS*WORD_W-1:0]   key_in;
  logic                          in_valid;
  logic                          in_ready;
  logic                          in_decrypt;
  logic [2*WORD_W-1:0]           in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [2*WORD_W-1:0]           out_data;
  logic                          key_loaded;

  modport master (
    output key_valid, key_in, in_valid, in_decrypt, in_data, out_ready,
    input  key_ready, in_ready, out_valid, out_data, key_loaded
  );

  modport slave (
    input  key_valid, key_in, in_valid, in_decrypt, in_data, out_ready,
    output key_ready, in_ready, out_valid, out_data, key_loaded
  );
endinterface

// File: rtl/simon_key_store.sv
// Round-key register file filled by an m-word sliding-window expander, one word per cycle for ROUNDS cycles.
// wr_start is ignored while busy; done flags the cycle of the final write; rd_key is an asynchronous read.
module simon_key_store import simon_pkg::*; #(
  parameter int WORD_W    = 32,
  parameter int KEY_WORDS = 4,
  parameter int ROUNDS    = 44,
  parameter int Z_IDX     = 3,
  parameter int CW        = cnt_w(ROUNDS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_start,
  input  logic [KEY_WORDS*WORD_W-1:0] key_in,
  output logic                        busy,
  output logic                        done,
  input  logic [CW-1:0]               rd_addr,
  output logic [WORD_W-1:0]           rd_key
);

  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  logic [WORD_W-1:0] mem [ROUNDS];
  logic [WORD_W-1:0] win [KEY_WORDS];
  logic [WORD_W-1:0] t;
  logic [WORD_W-1:0] nxt;
  logic [CW-1:0]     wcnt;
  logic [5:0]        zi;

  function automatic logic [WORD_W-1:0] rr(input logic [WORD_W-1:0] x, input int s);
    logic [63:0] r;
    r = ror(64'(x), WORD_W, s);
    return r[WORD_W-1:0];
  endfunction

  // win holds k[i..i+m-1] while k[i] is written, so nxt is k[i+m].
  always_comb begin
    t = rr(win[KEY_WORDS-1], 3);
    if (KEY_WORDS == 4) t = t ^ win[1];
    t   = t ^ rr(t, 1);
    nxt = ~win[0] ^ t ^ WORD_W'(z_bit(Z_IDX, zi)) ^ WORD_W'(3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      wcnt <= '0;
      zi   <= '0;
    end else if (busy) begin
      for (int j = 0; j < KEY_WORDS - 1; j++) win[j] <= win[j+1];
      win[KEY_WORDS-1] <= nxt;
      wcnt <= wcnt + 1'b1;
      zi   <= (zi == 6'd61) ? 6'd0 : zi + 6'd1;
      if (wcnt == LAST) busy <= 1'b0;
    end else if (wr_start) begin
      busy <= 1'b1;
      wcnt <= '0;
      zi   <= '0;
      for (int j = 0; j < KEY_WORDS; j++) win[j] <= key_in[j*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (busy) mem[wcnt] <= win[0];
  end

  assign done   = busy && (wcnt == LAST);
  assign rd_key = mem[rd_addr];

endmodule

// File: rtl/simon_iter_core.sv
// Iterative SIMON encrypt/decrypt, one round per clock; result valid ROUNDS edges after block accept.
// Holds out_data until out_ready; no new key or block is accepted outside IDLE.
module simon_iter_core import simon_pkg::*; #(
  parameter int WORD_W    = 32,
  parameter int KEY_WORDS = 4,
  parameter int ROUNDS    = 44,
  parameter int Z_IDX     = 3
) (
  input  logic              clk,
  input  logic              rst,
  simon_iter_core_if.slave  bus
);

  localparam int            CW   = cnt_w(ROUNDS);
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       rd_addr;
  logic [WORD_W-1:0]   xr;
  logic [WORD_W-1:0]   yr;
  logic [WORD_W-1:0]   rk;
  logic [WORD_W-1:0]   nx;
  logic                dec;
  logic                key_ready_q;
  logic                key_loaded_q;
  logic                out_valid_q;
  logic [2*WORD_W-1:0] out_data_q;
  logic                ks_start;
  logic                ks_busy;
  logic                ks_done;
  logic                accept;

  function automatic logic [WORD_W-1:0] rl(input logic [WORD_W-1:0] x, input int s);
    logic [63:0] r;
    r = rol(64'(x), WORD_W, s);
    return r[WORD_W-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] f(input logic [WORD_W-1:0] x);
    return (rl(x, 1) & rl(x, 8)) ^ rl(x, 2);
  endfunction

  simon_key_store #(
    .WORD_W    (WORD_W),
    .KEY_WORDS (KEY_WORDS),
    .ROUNDS    (ROUNDS),
    .Z_IDX     (Z_IDX),
    .CW        (CW)
  ) u_ks (
    .clk      (clk),
    .rst      (rst),
    .wr_start (ks_start),
    .key_in   (bus.key_in),
    .busy     (ks_busy),
    .done     (ks_done),
    .rd_addr  (rd_addr),
    .rd_key   (rk)
  );

  // A key request in IDLE pre-empts a block offered in the same cycle.
  assign ks_start       = key_ready_q & bus.key_valid & ~ks_busy;
  assign bus.key_ready  = key_ready_q;
  assign bus.in_ready   = key_ready_q & key_loaded_q & ~bus.key_valid;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.key_loaded = key_loaded_q;
  assign accept         = bus.in_valid & bus.in_ready;

  // Decryption runs the encrypt round on swapped halves with keys walked backwards.
  assign rd_addr = dec ? (LAST - cnt) : cnt;
  assign nx      = yr ^ f(xr) ^ rk;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      xr           <= '0;
      yr           <= '0;
      dec          <= 1'b0;
      key_ready_q  <= 1'b1;
      key_loaded_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ks_start) begin
            state        <= KEXP;
            key_ready_q  <= 1'b0;
            key_loaded_q <= 1'b0;
          end else if (accept) begin
            state       <= RUN;
            key_ready_q <= 1'b0;
            dec         <= bus.in_decrypt;
            cnt         <= '0;
            if (bus.in_decrypt) begin
              xr <= bus.in_data[WORD_W-1:0];
              yr <= bus.in_data[2*WORD_W-1:WORD_W];
            end else begin
              xr <= bus.in_data[2*WORD_W-1:WORD_W];
              yr <= bus.in_data[WORD_W-1:0];
            end
          end
        end
        KEXP: begin
          if (ks_done) begin
            state        <= IDLE;
            key_ready_q  <= 1'b1;
            key_loaded_q <= 1'b1;
          end
        end
        RUN: begin
          xr  <= nx;
          yr  <= xr;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= dec ? {xr, nx} : {nx, xr};
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            key_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
